// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the femtoRV32 decode-to-execute pipeline register.
// Latency: none (types, constants and a helper function only).
// Backpressure: not applicable.
package id_ex_stage_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 12;

    // Bit positions inside the packed decode control bundle.
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_JUMP     = 6;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Contents of the EX slot, kept as one packed word so reset and bubbles
    // are a single assignment.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } ex_slot_t;

    function automatic logic is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard comparator: an EX-stage load feeding the instruction in decode.
// Latency: purely combinational.
// Backpressure: output forced low while the pipeline is stalled downstream.
//
// Ports:
//   ex_valid, ex_mem_read, ex_rd : instruction currently in the EX slot
//   id_valid, id_rs1, id_rs2     : instruction currently in decode
//   stall                        : downstream hold
//   load_use_stall               : request to hold fetch/decode for one cycle
module id_ex_hazard
    import id_ex_stage_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       stall,
    output logic       load_use_stall
);

    logic rd_match;

    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    assign rd_match = (ex_rd != REG_X0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign load_use_stall = !stall && ex_valid && ex_mem_read && id_valid && rd_match;

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use bubble insertion.
// Latency: 1 cycle decode->EX; a load-use hazard costs exactly one bubble.
// Backpressure: stall freezes every EX register; load_use_stall asks upstream to hold.
//
// Optional feature macro: FORWARD_WB_EN -- when defined, a writeback to a
// source register in the same cycle is bypassed into the captured operand.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id_*                     : decode instruction (valid, pc, indices, operands, imm, ctrl)
//   wb_regwrite, wb_rd, wb_data : register file write port (bypass source)
//   stall, flush             : downstream hold, redirect kill
//   load_use_stall           : hold request to fetch/decode
//   ex_*                     : registered EX slot contents
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              stall,
    input  logic              flush,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl
);

    ex_slot_t        ex_q;
    logic [XLEN-1:0] rs1_operand;
    logic [XLEN-1:0] rs2_operand;

    id_ex_hazard u_hazard (
        .ex_valid       (ex_q.valid),
        .ex_mem_read    (is_load(ex_q.ctrl)),
        .ex_rd          (ex_q.rd),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .stall          (stall),
        .load_use_stall (load_use_stall)
    );

`ifdef FORWARD_WB_EN
    // The register file is written at the same edge we capture, so its read
    // data is stale for a matching index; take the writeback value instead.
    assign rs1_operand = (wb_regwrite && (wb_rd != REG_X0) && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
    assign rs2_operand = (wb_regwrite && (wb_rd != REG_X0) && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;
`else
    assign rs1_operand = id_rs1_data;
    assign rs2_operand = id_rs2_data;

    logic unused_wb;
    assign unused_wb = &{1'b0, wb_regwrite, wb_rd, wb_data};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (!stall) begin
            if (flush || load_use_stall) begin
                // Bubble: zero everything so a dead slot carries no stale control.
                ex_q <= '0;
            end else begin
                ex_q.valid    <= id_valid;
                ex_q.pc       <= id_pc;
                ex_q.rs1_data <= rs1_operand;
                ex_q.rs2_data <= rs2_operand;
                ex_q.imm      <= id_imm;
                ex_q.rs1      <= id_rs1;
                ex_q.rs2      <= id_rs2;
                ex_q.rd       <= id_rd;
                ex_q.ctrl     <= id_valid ? id_ctrl : '0;
            end
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_ctrl     = ex_q.ctrl;

endmodule
